// File: rtl/align_add_stage.sv
// Signed-magnitude mantissa add/subtract on exponent-aligned HCORDIC operands,
// with a 2-entry skid buffer so the downstream normalise stage can stall.
module align_add_stage #(
    parameter int unsigned EXT_W  = 36,
    parameter int unsigned MANT_W = 27,
    parameter int unsigned TAG_W  = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          idle_in,
    input  logic [EXT_W-1:0]    cout_in,
    input  logic [EXT_W-1:0]    zout_in,
    input  logic [31:0]         sout_in,
    input  logic [1:0]          modeout_in,
    input  logic                operationout_in,
    input  logic                NatLogFlagout_in,
    input  logic [TAG_W-1:0]    InsTag_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [1:0]          idle_out,
    output logic                sum_sign,
    output logic [7:0]          sum_exponent,
    output logic [MANT_W:0]     sum_mantissa,
    output logic [EXT_W-1:0]    cout_out,
    output logic [EXT_W-1:0]    zout_out,
    output logic [31:0]         sout_out,
    output logic [1:0]          modeout_out,
    output logic                operationout_out,
    output logic                NatLogFlagout_out,
    output logic [TAG_W-1:0]    InsTag_out
);

    localparam logic [1:0] PUT_IDLE = 2'b10;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    typedef struct packed {
        logic [1:0]       idle;
        logic             sign;
        logic [7:0]       exponent;
        logic [MANT_W:0]  mantissa;
        logic [EXT_W-1:0] c;
        logic [EXT_W-1:0] z;
        logic [31:0]      s;
        logic [1:0]       mode;
        logic             operation;
        logic             natlog;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [1:0] count_q, count_d;
    entry_t     entry0_q, entry0_d;
    entry_t     entry1_q, entry1_d;
    entry_t     new_entry;

    logic              c_sign, z_sign;
    logic [MANT_W-1:0] cm, zm;
    logic              push, pop;

    assign c_sign = cout_in[EXT_W-1];
    assign z_sign = zout_in[EXT_W-1];
    assign cm     = cout_in[MANT_W-1:0];
    assign zm     = zout_in[MANT_W-1:0];

    always_comb begin
        new_entry           = '0;
        new_entry.idle      = idle_in;
        new_entry.c         = cout_in;
        new_entry.z         = zout_in;
        new_entry.s         = sout_in;
        new_entry.mode      = modeout_in;
        new_entry.operation = operationout_in;
        new_entry.natlog    = NatLogFlagout_in;
        new_entry.tag       = InsTag_in;
        new_entry.exponent  = cout_in[EXT_W-2:MANT_W];
        if (idle_in == PUT_IDLE) begin
            new_entry.exponent = zout_in[EXT_W-2:MANT_W];
        end else if (c_sign == z_sign) begin
            new_entry.mantissa = {1'b0, cm} + {1'b0, zm};
            new_entry.sign     = c_sign;
        end else if (cm > zm) begin
            new_entry.mantissa = {1'b0, cm - zm};
            new_entry.sign     = c_sign;
        end else if (zm > cm) begin
            new_entry.mantissa = {1'b0, zm - cm};
            new_entry.sign     = z_sign;
        end
        // exact cancellation falls through to +0
    end

    assign out_valid = (count_q != EMPTY);
    assign in_ready  = (count_q != FULL);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        count_d  = count_q;
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        case (count_q)
            EMPTY: begin
                if (push) begin
                    entry0_d = new_entry;
                    count_d  = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    entry0_d = new_entry;
                end else if (push) begin
                    entry1_d = new_entry;
                    count_d  = FULL;
                end else if (pop) begin
                    count_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    entry0_d = entry1_q;
                    count_d  = ONE;
                end
            end
            default: count_d = EMPTY;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q  <= EMPTY;
            entry0_q <= '0;
            entry1_q <= '0;
        end else begin
            count_q  <= count_d;
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
        end
    end

    assign idle_out          = entry0_q.idle;
    assign sum_sign          = entry0_q.sign;
    assign sum_exponent      = entry0_q.exponent;
    assign sum_mantissa      = entry0_q.mantissa;
    assign cout_out          = entry0_q.c;
    assign zout_out          = entry0_q.z;
    assign sout_out          = entry0_q.s;
    assign modeout_out       = entry0_q.mode;
    assign operationout_out  = entry0_q.operation;
    assign NatLogFlagout_out = entry0_q.natlog;
    assign InsTag_out        = entry0_q.tag;

endmodule

// File: tb/tb_align_add_stage.sv
// Bench for align_add_stage: directed scenarios plus randomized traffic against a
// signed-arithmetic reference model and a FIFO of expected results.
module tb_align_add_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  idle_in;
    logic [35:0] cout_in, zout_in;
    logic [31:0] sout_in;
    logic [1:0]  modeout_in;
    logic        operationout_in, NatLogFlagout_in;
    logic [7:0]  InsTag_in;
    logic        out_valid, out_ready;
    logic [1:0]  idle_out;
    logic        sum_sign;
    logic [7:0]  sum_exponent;
    logic [27:0] sum_mantissa;
    logic [35:0] cout_out, zout_out;
    logic [31:0] sout_out;
    logic [1:0]  modeout_out;
    logic        operationout_out, NatLogFlagout_out;
    logic [7:0]  InsTag_out;

    always #5 clock = ~clock;

    align_add_stage dut (
        .clock             (clock),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .idle_in           (idle_in),
        .cout_in           (cout_in),
        .zout_in           (zout_in),
        .sout_in           (sout_in),
        .modeout_in        (modeout_in),
        .operationout_in   (operationout_in),
        .NatLogFlagout_in  (NatLogFlagout_in),
        .InsTag_in         (InsTag_in),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .idle_out          (idle_out),
        .sum_sign          (sum_sign),
        .sum_exponent      (sum_exponent),
        .sum_mantissa      (sum_mantissa),
        .cout_out          (cout_out),
        .zout_out          (zout_out),
        .sout_out          (sout_out),
        .modeout_out       (modeout_out),
        .operationout_out  (operationout_out),
        .NatLogFlagout_out (NatLogFlagout_out),
        .InsTag_out        (InsTag_out)
    );

    typedef struct packed {
        logic [1:0]  idle;
        logic        sign;
        logic [7:0]  exponent;
        logic [27:0] mant;
        logic [35:0] c, z;
        logic [31:0] s;
        logic [1:0]  mode;
        logic        op, nat;
        logic [7:0]  tag;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   check_en = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: treat each operand as a signed integer and add.
    function automatic exp_t ref_model();
        exp_t   e;
        longint vc, vz, sum, mag;
        e      = '0;
        e.idle = idle_in;
        e.c    = cout_in;
        e.z    = zout_in;
        e.s    = sout_in;
        e.mode = modeout_in;
        e.op   = operationout_in;
        e.nat  = NatLogFlagout_in;
        e.tag  = InsTag_in;
        if (idle_in == 2'b10) begin
            e.exponent = zout_in[34:27];
        end else begin
            vc  = longint'(cout_in[26:0]);
            vz  = longint'(zout_in[26:0]);
            if (cout_in[35]) vc = -vc;
            if (zout_in[35]) vz = -vz;
            sum = vc + vz;
            mag = (sum < 0) ? -sum : sum;
            e.exponent = cout_in[34:27];
            e.mant     = mag[27:0];
            e.sign     = (cout_in[35] == zout_in[35]) ? cout_in[35] : (sum < 0);
        end
        return e;
    endfunction

    task automatic check_outputs();
        exp_t h;
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() != 2));
        if (q.size() != 0) begin
            h = q[0];
            chk("sum_mantissa", 64'(sum_mantissa), 64'(h.mant));
            chk("sum_sign", 64'(sum_sign), 64'(h.sign));
            chk("sum_exponent", 64'(sum_exponent), 64'(h.exponent));
            chk("idle_out", 64'(idle_out), 64'(h.idle));
            chk("cout_out", 64'(cout_out), 64'(h.c));
            chk("zout_out", 64'(zout_out), 64'(h.z));
            chk("sout_out", 64'(sout_out), 64'(h.s));
            chk("side", 64'({modeout_out, operationout_out, NatLogFlagout_out}),
                64'({h.mode, h.op, h.nat}));
            chk("InsTag_out", 64'(InsTag_out), 64'(h.tag));
        end
    endtask

    task automatic tick();
        bit   acc, pop;
        exp_t e;
        if (check_en) check_outputs();
        acc = in_valid && (q.size() < 2) && !reset;
        pop = (q.size() != 0) && out_ready && !reset;
        e   = ref_model();
        @(posedge clock);
        if (reset) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        @(negedge clock);
    endtask

    task automatic set_in(input logic v, input logic [1:0] idle, input logic [35:0] c,
                          input logic [35:0] z, input logic [7:0] tag);
        in_valid         = v;
        idle_in          = idle;
        cout_in          = c;
        zout_in          = z;
        InsTag_in        = tag;
        sout_in          = $urandom;
        modeout_in       = 2'($urandom);
        operationout_in  = 1'($urandom);
        NatLogFlagout_in = 1'($urandom);
    endtask

    task automatic scenario_add();
        set_in(1'b1, 2'b00, {1'b0, 8'h82, 27'h4000000}, {1'b0, 8'h82, 27'h2000000}, 8'h11);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("add_valid", 64'(out_valid), 64'd1);
        chk("add_mant", 64'(sum_mantissa), 64'h6000000);
        chk("add_exp", 64'(sum_exponent), 64'h82);
        chk("add_sign", 64'(sum_sign), 64'd0);
        chk("add_tag", 64'(InsTag_out), 64'h11);
        tick();
    endtask

    logic [35:0] rc, rz;
    logic [26:0] rm;
    logic [7:0]  rex;

    initial begin
        reset = 1'b1;
        out_ready = 1'b0;
        set_in(1'b1, 2'b00, '0, '0, 8'h00);
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        check_en = 1'b1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);

        scenario_add();

        // Opposite-sign subtract
        set_in(1'b1, 2'b00, {1'b0, 8'h85, 27'h2000000}, {1'b1, 8'h85, 27'h6000000}, 8'h22);
        tick();
        in_valid = 1'b0;
        chk("sub_mant", 64'(sum_mantissa), 64'h4000000);
        chk("sub_sign", 64'(sum_sign), 64'd1);
        chk("sub_exp", 64'(sum_exponent), 64'h85);
        tick();

        // Cancellation
        set_in(1'b1, 2'b00, {1'b1, 8'h70, 27'h1234567}, {1'b0, 8'h70, 27'h1234567}, 8'h33);
        tick();
        in_valid = 1'b0;
        chk("cancel_mant", 64'(sum_mantissa), 64'd0);
        chk("cancel_sign", 64'(sum_sign), 64'd0);
        tick();

        // Max-magnitude carry
        set_in(1'b1, 2'b00, {1'b1, 8'h7F, 27'h7FFFFFF}, {1'b1, 8'h7F, 27'h7FFFFFF}, 8'h44);
        tick();
        in_valid = 1'b0;
        chk("carry_mant", 64'(sum_mantissa), 64'hFFFFFFE);
        chk("carry_bit27", 64'(sum_mantissa[27]), 64'd1);
        tick();

        // put_idle
        rc = {1'b1, 8'h33, 27'h5A5A5A5};
        rz = {1'b0, 8'h90, 27'h0F0F0F0};
        set_in(1'b1, 2'b10, rc, rz, 8'h55);
        tick();
        in_valid = 1'b0;
        chk("idle_mant", 64'(sum_mantissa), 64'd0);
        chk("idle_exp", 64'(sum_exponent), 64'h90);
        chk("idle_cout", 64'(cout_out), 64'(rc));
        chk("idle_zout", 64'(zout_out), 64'(rz));
        chk("idle_idle", 64'(idle_out), 64'd2);
        tick();

        // Backpressure with tags 1,2,3
        out_ready = 1'b0;
        set_in(1'b1, 2'b00, {1'b0, 8'h80, 27'h100}, {1'b0, 8'h80, 27'h1}, 8'd1);
        tick();
        set_in(1'b1, 2'b00, {1'b0, 8'h80, 27'h200}, {1'b1, 8'h80, 27'h1}, 8'd2);
        tick();
        chk("bp_ready_low", 64'(in_ready), 64'd0);
        set_in(1'b1, 2'b00, {1'b1, 8'h80, 27'h300}, {1'b1, 8'h80, 27'h3}, 8'd3);
        tick();
        tick();
        chk("bp_stall_tag", 64'(InsTag_out), 64'd1);
        chk("bp_stall_mant", 64'(sum_mantissa), 64'h101);
        out_ready = 1'b1;
        tick();
        chk("bp_tag2", 64'(InsTag_out), 64'd2);
        chk("bp_ready_one", 64'(in_ready), 64'd1);
        tick();
        chk("bp_tag3", 64'(InsTag_out), 64'd3);
        chk("bp_count_kept", 64'({out_valid, in_ready}), 64'b11);
        in_valid = 1'b0;
        tick();
        chk("bp_drained", 64'(out_valid), 64'd0);

        // Reset with a full buffer
        out_ready = 1'b0;
        set_in(1'b1, 2'b01, {1'b0, 8'h81, 27'h7}, {1'b0, 8'h81, 27'h9}, 8'hA1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        chk("mrst_valid", 64'(out_valid), 64'd0);
        chk("mrst_ready", 64'(in_ready), 64'd1);
        chk("mrst_data", 64'({idle_out, sum_sign, sum_exponent, sum_mantissa, InsTag_out}),
            64'd0);
        chk("mrst_ops", 64'({cout_out, zout_out}), 64'd0);
        chk("mrst_pass", 64'({sout_out, modeout_out, operationout_out, NatLogFlagout_out}),
            64'd0);
        scenario_add();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rex = 8'($urandom);
            rm  = 27'($urandom);
            rc  = {1'($urandom), rex, rm};
            rm  = ($urandom_range(0, 7) == 0) ? rc[26:0] : 27'($urandom);
            rz  = {1'($urandom), ($urandom_range(0, 5) == 0) ? 8'($urandom) : rex, rm};
            set_in(1'($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 5) == 0) ? 2'b10 : 2'($urandom_range(0, 1)),
                   rc, rz, 8'($urandom));
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
